// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU, bus-select and state definitions
//
// Purpose: constants and types shared by the control sequencer and its
// instruction-field decoder.
//   - opcode constants (ir[31:27])
//   - alu_op encodings
//   - bus_sel bit indices for every bus source
//   - sequencer state enum
//   - aluOpFor(): maps an R-type or immediate opcode to its ALU operation
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_ADDI = 5'h0C;
  localparam logic [4:0] OP_ANDI = 5'h0D;
  localparam logic [4:0] OP_ORI  = 5'h0E;
  localparam logic [4:0] OP_MFHI = 5'h13;
  localparam logic [4:0] OP_MFLO = 5'h14;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  // Bus-source bit positions; R0..R15 occupy bits 0..15.
  localparam int SEL_R0     = 0;
  localparam int SEL_HI     = 16;
  localparam int SEL_LO     = 17;
  localparam int SEL_ZHI    = 18;
  localparam int SEL_ZLO    = 19;
  localparam int SEL_PC     = 20;
  localparam int SEL_MDR    = 21;
  localparam int SEL_INPORT = 22;
  localparam int SEL_C      = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HLT
  } state_t;

  // Immediate forms share the ALU operation of their register forms.
  function automatic logic [3:0] aluOpFor(input logic [4:0] op);
    case (op)
      OP_SUB:          aluOpFor = ALU_SUB;
      OP_AND, OP_ANDI: aluOpFor = ALU_AND;
      OP_OR,  OP_ORI:  aluOpFor = ALU_OR;
      default:         aluOpFor = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// rtl/ir_field_decode.sv - combinational opcode classification and register fields
//
// Purpose: splits the IR into opcode and Ra/Rb/Rc fields and classifies the
// opcode into exactly one of rtype/imm/mfhi/mflo/halt/illegal.
// Ports:
//   ir        in  32  instruction register contents
//   opcode    out 5   ir[31:27]
//   ra/rb/rc  out 4   ir[26:23] / ir[22:19] / ir[18:15]
//   isRtype, isImm, isMfhi, isMflo, isHalt, isIllegal  out 1  class flags
// Configuration: CTL_SEQ_MFHILO_EN enables MFHI/MFLO decode; without it those
// opcodes are classified illegal.
module ir_field_decode
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  opcode,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic        isRtype,
  output logic        isImm,
  output logic        isMfhi,
  output logic        isMflo,
  output logic        isHalt,
  output logic        isIllegal
);

  // Immediate value bits are consumed by the datapath, not by control.
  logic [14:0] unusedLow;
  assign unusedLow = ir[14:0];

  always_comb begin
    opcode  = ir[31:27];
    ra      = ir[26:23];
    rb      = ir[22:19];
    rc      = ir[18:15];
    isRtype = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    isImm   = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
    isHalt  = (opcode == OP_HALT);
`ifdef CTL_SEQ_MFHILO_EN
    isMfhi  = (opcode == OP_MFHI);
    isMflo  = (opcode == OP_MFLO);
`else
    isMfhi  = 1'b0;
    isMflo  = 1'b0;
`endif
    isIllegal = !(isRtype || isImm || isMfhi || isMflo || isHalt);
  end

endmodule

// File: rtl/ctl_sequencer.sv
// rtl/ctl_sequencer.sv - microstep control sequencer driving one-hot bus selects
//
// Purpose: runs fetch (T0-T2, with memory-ready wait in T1) and executes the
// register/immediate ALU subset, MFHI/MFLO and HALT (T3-T5).
// Ports:
//   clock, reset         in   rising-edge clock, synchronous active-high reset
//   run                  in   start pulse, sampled only in IDLE
//   ir                   in   32  IR contents, valid from T3
//   mem_rdy              in   memory read data valid
//   bus_sel              out  SEL_W one-hot bus source (or zero)
//   reg_in               out  N_REGS one-hot register load enables (or zero)
//   pc_in, ir_in, mar_in, mdr_in, y_in, z_in  out  register load strobes
//   inc_pc, mem_read     out  ALU increment / memory read request
//   alu_op               out  4  ALU operation, nonzero only in T4
//   halted, illegal      out  HALT reached / one-cycle unsupported-opcode pulse
// Configuration: CTL_SEQ_MFHILO_EN enables MFHI/MFLO (see ir_field_decode).
module ctl_sequencer
  import cpu_pkg::*;
#(
  parameter int N_REGS = 16,
  parameter int SEL_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [31:0]       ir,
  input  logic              mem_rdy,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [N_REGS-1:0] reg_in,
  output logic              pc_in,
  output logic              ir_in,
  output logic              mar_in,
  output logic              mdr_in,
  output logic              y_in,
  output logic              z_in,
  output logic              inc_pc,
  output logic              mem_read,
  output logic [3:0]        alu_op,
  output logic              halted,
  output logic              illegal
);

  localparam logic [SEL_W-1:0]  SEL_ONE = SEL_W'(1);
  localparam logic [N_REGS-1:0] REG_ONE = N_REGS'(1);

  state_t     state;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       isRtype, isImm, isMfhi, isMflo, isHalt, isIllegal;

  ir_field_decode uDecode (
    .ir        (ir),
    .opcode    (opcode),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .isRtype   (isRtype),
    .isImm     (isImm),
    .isMfhi    (isMfhi),
    .isMflo    (isMflo),
    .isHalt    (isHalt),
    .isIllegal (isIllegal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run) state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (mem_rdy) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (isRtype || isImm) state <= S_T4;
          else if (isHalt)      state <= S_HLT;
          else                  state <= S_T0;
        end
        S_T4:    state <= S_T5;
        S_T5:    state <= S_T0;
        S_HLT:   state <= S_HLT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs follow the state register (and ir in T3-T5). The T1 load strobes
  // additionally qualify on mem_rdy so PC and MDR load only when data is valid.
  always_comb begin
    bus_sel  = '0;
    reg_in   = '0;
    pc_in    = 1'b0;
    ir_in    = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    inc_pc   = 1'b0;
    mem_read = 1'b0;
    alu_op   = ALU_ADD;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_T0: begin
        bus_sel = SEL_ONE << SEL_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
      end
      S_T1: begin
        bus_sel  = SEL_ONE << SEL_ZLO;
        mem_read = 1'b1;
        pc_in    = mem_rdy;
        mdr_in   = mem_rdy;
      end
      S_T2: begin
        bus_sel = SEL_ONE << SEL_MDR;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (isRtype || isImm) begin
          bus_sel = SEL_ONE << rb;
          y_in    = 1'b1;
        end else if (isMfhi) begin
          bus_sel = SEL_ONE << SEL_HI;
          reg_in  = REG_ONE << ra;
        end else if (isMflo) begin
          bus_sel = SEL_ONE << SEL_LO;
          reg_in  = REG_ONE << ra;
        end else if (isIllegal) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        bus_sel = isRtype ? (SEL_ONE << rc) : (SEL_ONE << SEL_C);
        alu_op  = aluOpFor(opcode);
        z_in    = 1'b1;
      end
      S_T5: begin
        bus_sel = SEL_ONE << SEL_ZLO;
        reg_in  = REG_ONE << ra;
      end
      S_HLT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctl_sequencer.sv
// tb/tb_ctl_sequencer.sv - self-checking bench for ctl_sequencer
module tb_ctl_sequencer;

  typedef logic [61:0] ov_t;
  typedef struct {
    logic        rst;
    logic        run;
    logic        rdy;
    logic [31:0] ir;
    ov_t         exp;
  } vec_t;

  localparam logic [5:0] ST_PC  = 6'b100000;
  localparam logic [5:0] ST_IR  = 6'b010000;
  localparam logic [5:0] ST_MAR = 6'b001000;
  localparam logic [5:0] ST_MDR = 6'b000100;
  localparam logic [5:0] ST_Y   = 6'b000010;
  localparam logic [5:0] ST_Z   = 6'b000001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_rdy = 1'b0;
  logic [31:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
  logic        inc_pc, mem_read, halted, illegal;
  logic [3:0]  alu_op;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  ctl_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .ir       (ir),
    .mem_rdy  (mem_rdy),
    .bus_sel  (bus_sel),
    .reg_in   (reg_in),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .inc_pc   (inc_pc),
    .mem_read (mem_read),
    .alu_op   (alu_op),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  ov_t actual;
  assign actual = {bus_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                   inc_pc, mem_read, alu_op, halted, illegal};

  function automatic ov_t mk(input logic [31:0] bs, input logic [15:0] ri,
                             input logic [5:0] st, input logic inc, input logic mr,
                             input logic [3:0] alu, input logic h, input logic il);
    return {bs, ri, st, inc, mr, alu, h, il};
  endfunction

  ov_t eZero, eT0, eT1w, eT1r, eT2, eHalt, eIll;

  task automatic add(input logic rst, input logic rn, input logic rdy,
                     input logic [31:0] iw, input ov_t e);
    vec_t v;
    v.rst = rst; v.run = rn; v.rdy = rdy; v.ir = iw; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic applyAll(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset = vq[i].rst; run = vq[i].run; mem_rdy = vq[i].rdy; ir = vq[i].ir;
      #1;
      checks++;
      if (actual !== vq[i].exp) begin
        errors++;
        $display("FAIL %s[%0d] outputs: got %h expected %h", tag, i, actual, vq[i].exp);
      end
      checks++;
      if ($countones(bus_sel) > 1 || bus_sel[31:24] != 8'h00) begin
        errors++;
        $display("FAIL %s[%0d] bus_sel one-hot: got %h expected popcount<=1 and [31:24]=0",
                 tag, i, bus_sel);
      end
    end
    vq.delete();
  endtask

  function automatic logic rb1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: emits the expected per-cycle trace of one instruction
  // directly from the instruction's class and fields.
  task automatic pushInstr(input logic [31:0] iw, input int waits, output bit stop);
    logic [4:0] op;
    logic [3:0] ra, rb, rc, alu;
    bit rtype, imm, hi, lo;
    op = iw[31:27]; ra = iw[26:23]; rb = iw[22:19]; rc = iw[18:15];
    rtype = op inside {5'h03, 5'h04, 5'h05, 5'h06};
    imm   = op inside {5'h0C, 5'h0D, 5'h0E};
`ifdef CTL_SEQ_MFHILO_EN
    hi = (op == 5'h13); lo = (op == 5'h14);
`else
    hi = 1'b0; lo = 1'b0;
`endif
    stop = (op == 5'h1B);
    case (op)
      5'h04:        alu = 4'd1;
      5'h05, 5'h0D: alu = 4'd2;
      5'h06, 5'h0E: alu = 4'd3;
      default:      alu = 4'd0;
    endcase
    add(0, rb1(), rb1(), $urandom, eT0);
    for (int w = 0; w < waits; w++) add(0, rb1(), 1'b0, $urandom, eT1w);
    add(0, rb1(), 1'b1, $urandom, eT1r);
    add(0, rb1(), rb1(), $urandom, eT2);
    if (rtype || imm) begin
      add(0, rb1(), rb1(), iw, mk(32'd1 << rb, 16'h0, ST_Y, 0, 0, 4'd0, 0, 0));
      add(0, rb1(), rb1(), iw, mk(rtype ? (32'd1 << rc) : (32'd1 << 23), 16'h0, ST_Z, 0, 0, alu, 0, 0));
      add(0, rb1(), rb1(), iw, mk(32'd1 << 19, 16'd1 << ra, 6'd0, 0, 0, 4'd0, 0, 0));
    end else if (hi || lo) begin
      add(0, rb1(), rb1(), iw, mk(hi ? (32'd1 << 16) : (32'd1 << 17), 16'd1 << ra, 6'd0, 0, 0, 4'd0, 0, 0));
    end else if (stop) begin
      add(0, rb1(), rb1(), iw, eZero);
    end else begin
      add(0, rb1(), rb1(), iw, eIll);
    end
  endtask

  initial begin
    logic [31:0] iw;
    logic [4:0]  op;
    bit          stop;
    logic [4:0]  legal[10] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h0C, 5'h0D, 5'h0E, 5'h13, 5'h14, 5'h1B};

    eZero = mk(32'h0, 16'h0, 6'd0, 0, 0, 4'd0, 0, 0);
    eT0   = mk(32'h0010_0000, 16'h0, ST_MAR | ST_Z, 1, 0, 4'd0, 0, 0);
    eT1w  = mk(32'h0008_0000, 16'h0, 6'd0, 0, 1, 4'd0, 0, 0);
    eT1r  = mk(32'h0008_0000, 16'h0, ST_PC | ST_MDR, 0, 1, 4'd0, 0, 0);
    eT2   = mk(32'h0020_0000, 16'h0, ST_IR, 0, 0, 4'd0, 0, 0);
    eHalt = mk(32'h0, 16'h0, 6'd0, 0, 0, 4'd0, 1, 0);
    eIll  = mk(32'h0, 16'h0, 6'd0, 0, 0, 4'd0, 0, 1);

    // Hand-written vector table: {reset, run, mem_rdy, ir, expected outputs}
    add(1, 0, 0, 32'h0, eZero);
    add(1, 1, 1, 32'h0, eZero);
    add(0, 0, 0, 32'h0, eZero);
    add(0, 1, 0, 32'h0, eZero);
    // fetch with three wait cycles in T1; run ignored outside IDLE
    add(0, 1, 0, 32'h1234_5678, eT0);
    add(0, 0, 0, 32'h1234_5678, eT1w);
    add(0, 1, 0, 32'h1234_5678, eT1w);
    add(0, 0, 0, 32'h1234_5678, eT1w);
    add(0, 0, 1, 32'h1234_5678, eT1r);
    add(0, 0, 0, 32'h1234_5678, eT2);
    // ADD R3,R3,R3
    add(0, 1, 1, 32'h1999_8000, mk(32'h0000_0008, 16'h0, ST_Y, 0, 0, 4'd0, 0, 0));
    add(0, 0, 0, 32'h1999_8000, mk(32'h0000_0008, 16'h0, ST_Z, 0, 0, 4'd0, 0, 0));
    add(0, 0, 1, 32'h1999_8000, mk(32'h0008_0000, 16'h0008, 6'd0, 0, 0, 4'd0, 0, 0));
    // OR R5,R1,R9 follows with no IDLE gap
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 1, 32'h0, eT1r);
    add(0, 0, 0, 32'h0, eT2);
    add(0, 0, 0, 32'h328C_8000, mk(32'h0000_0002, 16'h0, ST_Y, 0, 0, 4'd0, 0, 0));
    add(0, 0, 0, 32'h328C_8000, mk(32'h0000_0200, 16'h0, ST_Z, 0, 0, 4'd3, 0, 0));
    add(0, 0, 0, 32'h328C_8000, mk(32'h0008_0000, 16'h0020, 6'd0, 0, 0, 4'd0, 0, 0));
    // ADDI R2,R2,imm
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 1, 32'h0, eT1r);
    add(0, 0, 0, 32'h0, eT2);
    add(0, 0, 0, 32'h6110_0000, mk(32'h0000_0004, 16'h0, ST_Y, 0, 0, 4'd0, 0, 0));
    add(0, 0, 0, 32'h6110_0000, mk(32'h0080_0000, 16'h0, ST_Z, 0, 0, 4'd0, 0, 0));
    add(0, 0, 0, 32'h6110_0000, mk(32'h0008_0000, 16'h0004, 6'd0, 0, 0, 4'd0, 0, 0));
    // MFHI R1
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 1, 32'h0, eT1r);
    add(0, 0, 0, 32'h0, eT2);
`ifdef CTL_SEQ_MFHILO_EN
    add(0, 0, 0, 32'h9880_0000, mk(32'h0001_0000, 16'h0002, 6'd0, 0, 0, 4'd0, 0, 0));
`else
    add(0, 0, 0, 32'h9880_0000, eIll);
`endif
    // opcode 0x1F: illegal for one cycle then T0
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 1, 32'h0, eT1r);
    add(0, 0, 0, 32'h0, eT2);
    add(0, 0, 0, 32'hF800_0000, eIll);
    // HALT sticks through run pulses
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 1, 32'h0, eT1r);
    add(0, 0, 0, 32'h0, eT2);
    add(0, 1, 0, 32'hD800_0000, eZero);
    add(0, 1, 1, 32'h0, eHalt);
    add(0, 0, 1, 32'h0, eHalt);
    add(0, 1, 0, 32'h0, eHalt);
    add(1, 0, 0, 32'h0, eHalt);
    // reset during T4
    add(0, 1, 0, 32'h0, eZero);
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 1, 32'h0, eT1r);
    add(0, 0, 0, 32'h0, eT2);
    add(0, 0, 0, 32'h1999_8000, mk(32'h0000_0008, 16'h0, ST_Y, 0, 0, 4'd0, 0, 0));
    add(1, 0, 0, 32'h1999_8000, mk(32'h0000_0008, 16'h0, ST_Z, 0, 0, 4'd0, 0, 0));
    add(0, 0, 0, 32'h1999_8000, eZero);
    add(0, 0, 0, 32'h1999_8000, eZero);
    // reset during the T1 wait
    add(0, 1, 0, 32'h0, eZero);
    add(0, 0, 0, 32'h0, eT0);
    add(0, 0, 0, 32'h0, eT1w);
    add(1, 0, 0, 32'h0, eT1w);
    add(0, 0, 1, 32'h0, eZero);
    add(0, 0, 1, 32'h0, eZero);
    applyAll("vec");

    // Randomized instruction stream checked against the trace model.
    add(0, 1, rb1(), $urandom, eZero);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do op = 5'($urandom_range(0, 31)); while (op inside {legal});
      end else begin
        op = legal[$urandom_range(0, 8)];
      end
      iw = $urandom;
      iw[31:27] = op;
      pushInstr(iw, $urandom_range(0, 3), stop);
    end
    iw = $urandom;
    iw[31:27] = 5'h1B;
    pushInstr(iw, $urandom_range(0, 2), stop);
    for (int k = 0; k < 4; k++) add(0, rb1(), rb1(), $urandom, eHalt);
    applyAll("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
